// File: rtl/y_risc_pkg.sv
// y_risc_pkg: shared widths, reset PC, PC step and fetch buffer entry type
package y_risc_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order ring of fetch entries with separate alloc, fill and read pointers
module fetch_buffer
  import y_risc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_valid,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_valid,
  input  logic [ILEN-1:0] fill_data,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc,
  output logic [ILEN-1:0] rd_inst,
  output logic            full,
  output logic [PW-1:0]   unfilled
);
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  fetch_entry_t  rd_entry;
  assign count    = alloc_ptr_q - rd_ptr_q;
  assign unfilled = alloc_ptr_q - fill_ptr_q;
  assign full     = count == PW'(DEPTH);
  assign rd_entry = ent_q[rd_ptr_q[AW-1:0]];
  assign rd_valid = (count != '0) && rd_entry.filled;
  assign rd_pc    = rd_entry.pc;
  assign rd_inst  = rd_entry.inst;
  // fills land in allocation order, so the oldest unfilled entry is always at fill_ptr
  always_comb begin
    ent_d       = ent_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = (rd_valid && rd_ready) ? rd_ptr_q + PW'(1) : rd_ptr_q;
    if (alloc_valid) begin
      ent_d[alloc_ptr_q[AW-1:0]] = '{pc: alloc_pc, inst: '0, filled: 1'b0};
      alloc_ptr_d = alloc_ptr_q + PW'(1);
    end
    if (fill_valid && unfilled != '0) begin
      ent_d[fill_ptr_q[AW-1:0]].inst   = fill_data;
      ent_d[fill_ptr_q[AW-1:0]].filled = 1'b1;
      fill_ptr_d = fill_ptr_q + PW'(1);
    end
    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q       <= '{default: '0};
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
    end else begin
      ent_q       <= ent_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generator, request gating, stale-response drop counter and redirect flush
module fetch_stage
  import y_risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_P = RESET_PC,
  parameter int BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int DW = PW + 3;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic            full, req_fire, rsp_fill, rsp_owned;
  logic [PW-1:0]   unfilled;
  assign imem_req_valid = rst_n && !redirect_valid && !full;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && drop_q == '0 && !redirect_valid;
  // a response during redirect retires one old-stream fetch, whether pending drop or unfilled
  assign rsp_owned      = imem_rsp_valid && (drop_q != '0 || unfilled != '0);
  always_comb begin
    pc_d   = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : req_fire ? pc_q + PC_STEP : pc_q;
    drop_d = redirect_valid ? drop_q + DW'(unfilled) - DW'(rsp_owned)
           : (imem_rsp_valid && drop_q != '0) ? drop_q - DW'(1) : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC_P;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .alloc_valid (req_fire),
    .alloc_pc    (pc_q),
    .fill_valid  (rsp_fill),
    .fill_data   (imem_rsp_data),
    .rd_ready    (inst_ready),
    .rd_valid    (inst_valid),
    .rd_pc       (inst_pc),
    .rd_inst     (inst_data),
    .full        (full),
    .unfilled    (unfilled)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against an in-order memory model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        q[$];
  int          cyc, lat, n_cmp, n_err, nreq, ndeliv, d0;
  logic [31:0] exp_pc;
  logic        s_rv, s_iv, s_rsp;
  logic [31:0] s_addr, s_pc;
  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one clock cycle: sample at negedge, advance the memory model just after posedge
  task automatic tick();
    logic rf, df, rs;
    @(negedge clk);
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid; s_pc = inst_pc; s_rsp = imem_rsp_valid;
    rf = imem_req_valid && imem_req_ready;
    df = inst_valid && inst_ready;
    rs = imem_rsp_valid;
    if (df) begin
      chk("deliver_pc", inst_pc, exp_pc);
      chk("deliver_data", inst_data, memfn(inst_pc));
      exp_pc += 32'd4;
      ndeliv++;
    end
    if (redirect_valid) begin
      chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      exp_pc = redirect_pc & ~32'h3;
    end
    nreq += int'(rf);
    @(posedge clk);
    #1;
    if (rs && q.size() > 0) void'(q.pop_front());
    if (rf) q.push_back('{addr: s_addr, due: cyc + lat});
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(q[0].addr);
    end
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_inst_pc", inst_pc, 32'd0);
    q.delete();
    imem_rsp_valid = 1'b0;
    tick();
    rst_n  = 1'b1;
    exp_pc = 32'd0;
    nreq   = 0;
  endtask
  initial begin
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    lat = 1; cyc = 0; n_cmp = 0; n_err = 0; nreq = 0; ndeliv = 0; exp_pc = '0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("c0_req_valid", 32'(s_rv), 32'd1);
    chk("c0_req_addr", s_addr, 32'd0);
    tick();
    chk("c1_inst_valid", 32'(s_iv), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stream_valid", 32'(s_iv), 32'd1);
      chk("stream_pc", s_pc, 32'(4 * k));
    end
    inst_ready = 1'b0;
    apply_reset();
    repeat (10) tick();
    chk("bp_req_count", 32'(nreq), 32'd4);
    chk("bp_req_valid", 32'(s_rv), 32'd0);
    chk("bp_inst_valid", 32'(s_iv), 32'd1);
    chk("bp_inst_pc", s_pc, 32'd0);
    inst_ready = 1'b1;
    repeat (10) tick();
    lat = 3;
    apply_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("rd_req_valid_R", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("rd_req_valid_R1", 32'(s_rv), 32'd1);
    chk("rd_req_addr_R1", s_addr, 32'h100);
    repeat (3) begin
      tick();
      chk("rd_drop_hidden", 32'(s_iv), 32'd0);
    end
    tick();
    chk("rd_first_valid", 32'(s_iv), 32'd1);
    chk("rd_first_pc", s_pc, 32'h100);
    repeat (8) tick();
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    chk("same_cyc_inst_valid", 32'(s_iv), 32'd1);
    chk("same_cyc_rsp_valid", 32'(s_rsp), 32'd1);
    chk("same_cyc_req_valid", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("align_req_addr", s_addr, 32'h200);
    tick();
    chk("align_gap", 32'(s_iv), 32'd0);
    tick();
    chk("align_first_pc", s_pc, 32'h200);
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_addr_f8", s_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr_fc", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_0", s_addr, 32'h0);
    repeat (6) tick();
    d0 = ndeliv;
    for (int i = 0; i < 400; i++) begin
      inst_ready     = $urandom_range(0, 3) != 0;
      imem_req_ready = $urandom_range(0, 3) != 0;
      lat            = int'($urandom_range(1, 4));
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc    = $urandom & 32'h0000_0FFF;
      tick();
    end
    redirect_valid = 1'b0; inst_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
    repeat (20) tick();
    chk("random_progress", 32'(ndeliv - d0 > 40), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
